// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter
// Shares one data-memory/IO bridge port between two requesters: the core
// load/store unit (m0) and a secondary master such as debug or DMA (m1).
// An accepted request is latched onto the mem_* outputs. Those outputs stay
// driven for MEM_LAT cycles. Read data, or a completion for a write, then goes
// back to the winner. When both requesters ask at once, the winner alternates
// (round-robin), so neither requester can starve the other.
//
// Ports
//   clk, rst              clock (rising edge); asynchronous active-low reset
//   mN_req/we/wmode       request, 1=write, write mode (N = 0, 1)
//   mN_addr/wdata         byte address, write data
//   mN_gnt                one-cycle pulse when the request is accepted
//   mN_rvalid/rdata       one-cycle completion pulse, captured read data
//   mem_write_en/mode     write strobe and write mode to the bridge
//   mem_addr/wdata        address and write data to the bridge
//   mem_rdata             read data from the bridge
module riscv_dmem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int WMODE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [WMODE_W-1:0] m0_wmode,
    input  logic [31:0]        m0_addr,
    input  logic [31:0]        m0_wdata,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [31:0]        m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [WMODE_W-1:0] m1_wmode,
    input  logic [31:0]        m1_addr,
    input  logic [31:0]        m1_wdata,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [31:0]        m1_rdata,
    output logic               mem_write_en,
    output logic [WMODE_W-1:0] mem_write_mode,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    logic [1:0]         state_reg;
    logic [2:0]         cnt_reg;
    logic               last_reg;
    logic               win_reg;
    logic               mem_write_en_reg;
    logic [WMODE_W-1:0] mem_write_mode_reg;
    logic [31:0]        mem_addr_reg;
    logic [31:0]        mem_wdata_reg;

    logic [1:0]         req_vec;
    logic [1:0]         we_vec;
    logic [WMODE_W-1:0] wmode_in [2];
    logic [31:0]        addr_in  [2];
    logic [31:0]        wdata_in [2];

    logic               accept;
    logic               win_next;
    logic               capture;

    logic               gnt_reg    [2];
    logic               rvalid_reg [2];
    logic [31:0]        rdata_reg  [2];

    assign req_vec     = {m1_req, m0_req};
    assign we_vec      = {m1_we, m0_we};
    assign wmode_in[0] = m0_wmode;
    assign wmode_in[1] = m1_wmode;
    assign addr_in[0]  = m0_addr;
    assign addr_in[1]  = m1_addr;
    assign wdata_in[0] = m0_wdata;
    assign wdata_in[1] = m1_wdata;

    // With a single requester, req_vec[1] gives its id directly. On a tie,
    // the requester that did not win last time gets the port.
    always_comb begin
        accept   = (state_reg == IDLE) && (req_vec != 2'b00);
        win_next = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
        capture  = (state_reg == ACCESS) && (cnt_reg == 3'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= IDLE;
            cnt_reg            <= 3'd0;
            last_reg           <= 1'b1;
            win_reg            <= 1'b0;
            mem_write_en_reg   <= 1'b0;
            mem_write_mode_reg <= '0;
            mem_addr_reg       <= 32'd0;
            mem_wdata_reg      <= 32'd0;
        end else begin
            // The strobe is set only on acceptance, so it lasts one cycle:
            // the first ACCESS cycle.
            mem_write_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        win_reg            <= win_next;
                        last_reg           <= win_next;
                        mem_write_en_reg   <= we_vec[win_next];
                        mem_write_mode_reg <= wmode_in[win_next];
                        mem_addr_reg       <= addr_in[win_next];
                        mem_wdata_reg      <= wdata_in[win_next];
                        cnt_reg            <= LAT_INIT;
                        state_reg          <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Per-requester grant, completion and read-data registers. Only the
    // current winner's read-data register is loaded; the other one keeps its
    // value.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        localparam logic ID = 1'(gi);
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                gnt_reg[gi]    <= 1'b0;
                rvalid_reg[gi] <= 1'b0;
                rdata_reg[gi]  <= 32'd0;
            end else begin
                gnt_reg[gi]    <= accept && (win_next == ID);
                rvalid_reg[gi] <= capture && (win_reg == ID);
                if (capture && (win_reg == ID)) begin
                    rdata_reg[gi] <= mem_rdata;
                end
            end
        end
    end

    assign m0_gnt         = gnt_reg[0];
    assign m0_rvalid      = rvalid_reg[0];
    assign m0_rdata       = rdata_reg[0];
    assign m1_gnt         = gnt_reg[1];
    assign m1_rvalid      = rvalid_reg[1];
    assign m1_rdata       = rdata_reg[1];
    assign mem_write_en   = mem_write_en_reg;
    assign mem_write_mode = mem_write_mode_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Testbench for riscv_dmem_arbiter.
// Two instances are used: dut_a with MEM_LAT=1 and dut_b with MEM_LAT=3.
// Expected completions go into a per-instance queue when the stimulus is
// driven. A negedge monitor pops and compares an entry on every rvalid.
module tb_riscv_dmem_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req    [2][2];
    logic        we     [2][2];
    logic [1:0]  wmode  [2][2];
    logic [31:0] addr   [2][2];
    logic [31:0] wdata  [2][2];
    logic        gnt    [2][2];
    logic        rvalid [2][2];
    logic [31:0] rdata  [2][2];
    logic        mem_we    [2];
    logic [1:0]  mem_mode  [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata_a;
    logic [31:0] mem_rdata_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    assign mem_rdata_a = mem_model(mem_addr[0]);

    riscv_dmem_arbiter #(.MEM_LAT(1), .WMODE_W(2)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_wmode(wmode[0][0]),
        .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_wmode(wmode[0][1]),
        .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]),
        .mem_write_en(mem_we[0]), .mem_write_mode(mem_mode[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata_a)
    );

    riscv_dmem_arbiter #(.MEM_LAT(3), .WMODE_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_wmode(wmode[1][0]),
        .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_wmode(wmode[1][1]),
        .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]),
        .mem_write_en(mem_we[1]), .mem_write_mode(mem_mode[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic id, input logic [31:0] data, input logic dc);
        exp_t e;
        e.id = id; e.data = data; e.dc = dc;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic drive(input int d, input int m, input logic w, input logic [1:0] mode,
                         input logic [31:0] a, input logic [31:0] wd);
        req[d][m] = 1'b1; we[d][m] = w; wmode[d][m] = mode;
        addr[d][m] = a;   wdata[d][m] = wd;
    endtask

    task automatic wait_gnt(input int d, input int m, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (gnt[d][m]) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_zero(input int d);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("zero_gnt d%0d m%0d", d, m), {31'd0, gnt[d][m]}, 32'd0);
            check($sformatf("zero_rvalid d%0d m%0d", d, m), {31'd0, rvalid[d][m]}, 32'd0);
            check($sformatf("zero_rdata d%0d m%0d", d, m), rdata[d][m], 32'd0);
        end
        check($sformatf("zero_mem_we d%0d", d), {31'd0, mem_we[d]}, 32'd0);
        check($sformatf("zero_mem_mode d%0d", d), {30'd0, mem_mode[d]}, 32'd0);
        check($sformatf("zero_mem_addr d%0d", d), mem_addr[d], 32'd0);
        check($sformatf("zero_mem_wdata d%0d", d), mem_wdata[d], 32'd0);
    endtask

    // Scoreboard monitor: every rvalid must match the oldest expected entry.
    task automatic mon(input int d);
        exp_t e;
        int   qs;
        if (gnt[d][0] && gnt[d][1]) check($sformatf("gnt_exclusive d%0d", d), 32'd1, 32'd0);
        if (rvalid[d][0] && rvalid[d][1]) check($sformatf("rvalid_exclusive d%0d", d), 32'd1, 32'd0);
        for (int m = 0; m < 2; m++) begin
            if (rvalid[d][m]) begin
                qs = (d == 0) ? q_a.size() : q_b.size();
                if (qs == 0) begin
                    check($sformatf("rvalid_unexpected d%0d m%0d", d, m), 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                    $display("txn dut%0d m%0d rdata=%h", d, m, rdata[d][m]);
                    check($sformatf("sb_id d%0d", d), 32'(m), {31'd0, e.id});
                    if (!e.dc) check($sformatf("sb_rdata d%0d m%0d", d, m), rdata[d][m], e.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        int c;
        int k;
        int prev;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; we[d][m] = 1'b0; wmode[d][m] = 2'd0;
                addr[d][m] = 32'd0; wdata[d][m] = 32'd0;
            end
        end
        mem_rdata_b = 32'd0;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        check_zero(0);
        check_zero(1);

        // Single read on the MEM_LAT=1 instance.
        drive(0, 0, 1'b0, 2'd0, 32'h0000_0010, 32'd0);
        push(0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        wait_gnt(0, 0, c);
        req[0][0] = 1'b0;
        check("rd_gnt_cycle", 32'(c), 32'd1);
        check("rd_mem_we_c1", {31'd0, mem_we[0]}, 32'd0);
        check("rd_mem_addr", mem_addr[0], 32'h0000_0010);
        step();
        check("rd_rvalid_c2", {31'd0, rvalid[0][0]}, 32'd1);
        check("rd_mem_we_c2", {31'd0, mem_we[0]}, 32'd0);
        check("rd_m1_gnt", {31'd0, gnt[0][1]}, 32'd0);
        check("rd_m1_rvalid", {31'd0, rvalid[0][1]}, 32'd0);
        check("rd_m1_rdata", rdata[0][1], 32'd0);
        step();

        // Single write from m1.
        drive(0, 1, 1'b1, 2'd2, 32'hFFFF_FC04, 32'h1234_5678);
        push(0, 1'b1, 32'd0, 1'b1);
        wait_gnt(0, 1, c);
        req[0][1] = 1'b0;
        check("wr_gnt_cycle", 32'(c), 32'd1);
        check("wr_mem_we_c1", {31'd0, mem_we[0]}, 32'd1);
        check("wr_mem_addr", mem_addr[0], 32'hFFFF_FC04);
        check("wr_mem_wdata", mem_wdata[0], 32'h1234_5678);
        check("wr_mem_mode", {30'd0, mem_mode[0]}, 32'd2);
        step();
        check("wr_mem_we_c2", {31'd0, mem_we[0]}, 32'd0);
        check("wr_rvalid_c2", {31'd0, rvalid[0][1]}, 32'd1);
        check("wr_m0_rdata_kept", rdata[0][0], 32'hDEAD_BEEF);
        step();
        check("idle_mem_addr_held", mem_addr[0], 32'hFFFF_FC04);
        check("idle_mem_we", {31'd0, mem_we[0]}, 32'd0);

        // m1 raises its request while an m0 transaction is in flight.
        drive(0, 0, 1'b0, 2'd0, 32'h0000_0020, 32'd0);
        push(0, 1'b0, mem_model(32'h0000_0020), 1'b0);
        wait_gnt(0, 0, c);
        req[0][0] = 1'b0;
        drive(0, 1, 1'b0, 2'd0, 32'h0000_0030, 32'd0);
        push(0, 1'b1, mem_model(32'h0000_0030), 1'b0);
        wait_gnt(0, 1, c);
        req[0][1] = 1'b0;
        check("busy_m1_gnt_cycle", 32'(c + 1), 32'd4);
        step(); step(); step();

        // Continuous tie after a fresh reset: m0, m1, m0, m1 every 3 cycles.
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive(0, 0, 1'b0, 2'd0, 32'h0000_0100, 32'd0);
        drive(0, 1, 1'b0, 2'd0, 32'h0000_0200, 32'd0);
        k = 0;
        prev = 0;
        for (int cy = 1; cy <= 40 && k < 4; cy++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (gnt[0][m]) begin
                    check($sformatf("tie_order_%0d", k), 32'(m), 32'(k % 2));
                    if (k > 0) check($sformatf("tie_spacing_%0d", k), 32'(cy - prev), 32'd3);
                    prev = cy;
                    push(0, m[0], mem_model(addr[0][m]), 1'b0);
                    k++;
                end
            end
            if (k == 4) begin
                req[0][0] = 1'b0;
                req[0][1] = 1'b0;
            end
        end
        check("tie_count", 32'(k), 32'd4);
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        step(); step(); step();

        // MEM_LAT=3 read: capture the value present in the third ACCESS cycle.
        drive(1, 0, 1'b0, 2'd0, 32'h0000_0040, 32'd0);
        push(1, 1'b0, 32'h0000_0003, 1'b0);
        mem_rdata_b = 32'd0;
        wait_gnt(1, 0, c);
        req[1][0] = 1'b0;
        check("lat3_gnt_cycle", 32'(c), 32'd1);
        mem_rdata_b = 32'd1;
        step(); mem_rdata_b = 32'd2;
        step(); mem_rdata_b = 32'd3;
        check("lat3_rvalid_c3", {31'd0, rvalid[1][0]}, 32'd0);
        step(); mem_rdata_b = 32'd4;
        check("lat3_rvalid_c4", {31'd0, rvalid[1][0]}, 32'd1);
        step();

        // Reset in the second ACCESS cycle drops the transaction.
        drive(1, 0, 1'b1, 2'd1, 32'h0000_0050, 32'hAAAA_5555);
        push(1, 1'b0, 32'd0, 1'b1);
        wait_gnt(1, 0, c);
        req[1][0] = 1'b0;
        check("rst_mem_we_c1", {31'd0, mem_we[1]}, 32'd1);
        step();
        rst = 1'b0;
        #1;
        check_zero(1);
        void'(q_b.pop_back());
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step();
        mem_rdata_b = 32'hCAFE_0003;
        drive(1, 0, 1'b0, 2'd0, 32'h0000_0060, 32'd0);
        drive(1, 1, 1'b0, 2'd0, 32'h0000_0070, 32'd0);
        push(1, 1'b0, 32'hCAFE_0003, 1'b0);
        wait_gnt(1, 0, c);
        check("post_rst_tie_m1_gnt", {31'd0, gnt[1][1]}, 32'd0);
        req[1][0] = 1'b0;
        req[1][1] = 1'b0;
        check("post_rst_gnt_cycle", 32'(c), 32'd1);
        for (int i = 0; i < 6; i++) step();

        check("sb_drained", 32'(q_a.size() + q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_arbiter.md
Name: riscv_dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single data-memory/IO bridge port.
- Requester 0 is the core load/store unit. Requester 1 is a secondary master (debug/DMA).
- Each request is latched, the shared port is driven for a fixed memory latency, and read data or a write acknowledge is returned to the winner.
- Ties are resolved round-robin, so neither side starves.

Parameters:
- MEM_LAT, 1, cycles from address presented on mem_* to valid mem_rdata; legal range 1..7.
- WMODE_W, 2, width of the write-mode field; equals CACHE_D_WRITE_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- m0_req  in  1  requester 0 transaction request.
- m0_we  in  1  1 = write, 0 = read.
- m0_wmode  in  WMODE_W  SW/SH/SB write mode, passed through unchanged.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  write data.
- m0_gnt  out  1  one-cycle pulse: request accepted.
- m0_rvalid  out  1  one-cycle pulse: transaction complete, m0_rdata valid.
- m0_rdata  out  32  captured read data.
- m1_req, m1_we, m1_wmode, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for requester 1.
- mem_write_en  out  1  write strobe to bridge.
- mem_write_mode  out  WMODE_W  write mode to bridge.
- mem_addr  out  32  address to bridge.
- mem_wdata  out  32  data to bridge.
- mem_rdata  in  32  read data from bridge.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE; counter=0; last-winner pointer=1, so m0 wins the first tie.
  - All outputs 0: gnt, rvalid, rdata, and all mem_* outputs.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both req: the requester not equal to last-winner wins.
  - On the edge: latch winner id, we, wmode, addr and wdata into mem_* registers; set counter=MEM_LAT; update last-winner; assert winner gnt for the next cycle; go to ACCESS.
- ACCESS (cycles 1..MEM_LAT after acceptance):
  - mem_addr, mem_wdata and mem_write_mode are held constant.
  - mem_write_en=1 only in the first ACCESS cycle, and only if we=1; otherwise 0.
  - Counter decrements each cycle. In the cycle where counter==1, mem_rdata is captured into the winner's rdata register and state goes to RESP.
  - The loser's rdata register is unchanged.
- RESP (one cycle): winner rvalid=1, then state goes to IDLE.
  - Writes also get rvalid; the rdata captured on a write is don't-care.
- Timing (acceptance edge at end of cycle 0):
  - gnt in cycle 1; write strobe in cycle 1.
  - rvalid in cycle MEM_LAT+1.
  - Next acceptance decision in cycle MEM_LAT+2.
  - Sustained throughput: one transaction per MEM_LAT+2 cycles.
- Requester rules:
  - Hold req and its fields stable until gnt is seen.
  - Drop req the cycle after gnt unless a new transaction is intended.
  - A req still high when the FSM re-enters IDLE is a new transaction.
- Requests arriving in ACCESS/RESP are ignored until IDLE (no queuing).
- mem_addr, mem_wdata and mem_write_mode keep their last values in IDLE. mem_write_en is never high outside the first ACCESS cycle.
- gnt and rvalid are never high for both requesters in the same cycle.
- Reset mid-transaction:
  - Transaction is dropped; no rvalid is issued.
  - mem_write_en falls immediately.
  - Requesters must reissue after rst=1.
- Address decode (IO vs cache) and sub-word read extraction are not done here; they belong to the bridge and the requester respectively.

Test Plan:
- Single read, MEM_LAT=1: m0 reads addr 0x00000010, mem model returns 0xDEADBEEF. Expect m0_gnt in cycle 1, mem_write_en=0 throughout, m0_rvalid in cycle 2 with m0_rdata=0xDEADBEEF, and m1 outputs stay 0.
- Single write, MEM_LAT=1: m1 writes 0x12345678 to 0xFFFFFC04 with mode SW. Expect mem_write_en high exactly cycle 1 with mem_addr=0xFFFFFC04 and mem_wdata=0x12345678, and m1_rvalid in cycle 2.
- Simultaneous requests after reset: both req continuously for 4 transactions. Expect grant order m0, m1, m0, m1, with grants spaced MEM_LAT+2 cycles.
- MEM_LAT=3 read: mem_rdata changes each cycle (0x1, 0x2, 0x3, ...). Expect capture of the value present in ACCESS cycle 3, and rvalid in cycle 4.
- Request during busy: m1 raises req in cycle 1 of an m0 transaction. Expect m1_gnt no earlier than cycle MEM_LAT+3, and m0 unaffected.
- Reset mid-ACCESS (MEM_LAT=3): assert rst=0 in cycle 2. Expect all outputs 0 asynchronously, no rvalid after release, and the next request accepted normally with m0 winning a tie.
